// File: rtl/maxnet_host_ctrl.sv
// ============================================================================
// Module   : maxnet_host_ctrl
// Brief    : Host-side initiator for the Maxnet core. Loads eps/a1..a4 from a
//            serial word stream, pulses start, waits for finish, returns the
//            result on a valid/ready port. Optional watchdog: MAXNET_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module maxnet_host_ctrl #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        mx_start,
    output logic [31:0] mx_eps,
    output logic [31:0] mx_a1,
    output logic [31:0] mx_a2,
    output logic [31:0] mx_a3,
    output logic [31:0] mx_a4,
    input  logic        mx_finish,
    input  logic        mx_overflow,
    input  logic [31:0] mx_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_overflow,
    output logic        res_timeout,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    logic [2:0]  r_idx;
    logic        r_in_ready;
    logic        r_start;
    logic        r_busy;
    logic [31:0] r_eps;
    logic [31:0] r_a1;
    logic [31:0] r_a2;
    logic [31:0] r_a3;
    logic [31:0] r_a4;
    logic        r_res_valid;
    logic [31:0] r_res_data;
    logic        r_res_overflow;
    logic        r_res_timeout;

    logic        w_accept;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign w_accept = (r_state == S_LOAD) && r_in_ready && in_valid;

`ifdef MAXNET_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WD_W-1:0] r_wd;
    logic [c_WD_W-1:0] w_wd_next;
    logic              w_wd_expire;

    assign w_wd_next   = r_wd + 1'b1;
    assign w_wd_expire = (w_wd_next == c_WD_W'(TIMEOUT_CYCLES));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_LOAD;
            r_idx          <= 3'd0;
            r_in_ready     <= 1'b0;
            r_start        <= 1'b0;
            r_busy         <= 1'b0;
            r_eps          <= 32'h0;
            r_a1           <= 32'h0;
            r_a2           <= 32'h0;
            r_a3           <= 32'h0;
            r_a4           <= 32'h0;
            r_res_valid    <= 1'b0;
            r_res_data     <= 32'h0;
            r_res_overflow <= 1'b0;
            r_res_timeout  <= 1'b0;
`ifdef MAXNET_TIMEOUT_EN
            r_wd           <= '0;
`endif
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        case (r_idx)
                            3'd0:    r_eps <= in_data;
                            3'd1:    r_a1  <= in_data;
                            3'd2:    r_a2  <= in_data;
                            3'd3:    r_a3  <= in_data;
                            default: r_a4  <= in_data;
                        endcase
                        if (r_idx == 3'd4) begin
                            r_idx      <= 3'd0;
                            r_state    <= S_START;
                            r_start    <= 1'b1;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end

                // Finish is deliberately not looked at here so a level left
                // over from the previous run cannot complete this one.
                S_START: begin
                    r_start <= 1'b0;
                    r_state <= S_WAIT;
`ifdef MAXNET_TIMEOUT_EN
                    r_wd    <= '0;
`endif
                end

                S_WAIT: begin
                    if (mx_finish) begin
                        r_res_data     <= mx_out;
                        r_res_overflow <= mx_overflow;
                        r_res_timeout  <= 1'b0;
                        r_res_valid    <= 1'b1;
                        r_state        <= S_RESP;
`ifdef MAXNET_TIMEOUT_EN
                    end else if (w_wd_expire) begin
                        r_res_data     <= 32'h0;
                        r_res_overflow <= 1'b0;
                        r_res_timeout  <= 1'b1;
                        r_res_valid    <= 1'b1;
                        r_state        <= S_RESP;
                    end else begin
                        r_wd <= w_wd_next;
`endif
                    end
                end

                S_RESP: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_LOAD;
                    end
                end

                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign mx_start     = r_start;
    assign busy         = r_busy;
    assign mx_eps       = r_eps;
    assign mx_a1        = r_a1;
    assign mx_a2        = r_a2;
    assign mx_a3        = r_a3;
    assign mx_a4        = r_a4;
    assign res_valid    = r_res_valid;
    assign res_data     = r_res_data;
    assign res_overflow = r_res_overflow;
    assign res_timeout  = r_res_timeout;

endmodule

`default_nettype wire

// File: tb/tb_maxnet_host_ctrl.sv
// ============================================================================
// Module   : tb_maxnet_host_ctrl
// Brief    : Directed plus randomized bench for maxnet_host_ctrl with a stub
//            core; watchdog steps are built only with MAXNET_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_maxnet_host_ctrl;

    localparam int c_TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        mx_start;
    logic [31:0] mx_eps, mx_a1, mx_a2, mx_a3, mx_a4;
    logic        mx_finish = 1'b0;
    logic        mx_overflow = 1'b0;
    logic [31:0] mx_out = 32'h0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_overflow;
    logic        res_timeout;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference state: last accepted operand words and the expected response.
    logic [31:0] m_ops [5];
    logic [31:0] m_data;
    logic        m_ovf;
    logic        m_tmo;
    logic [31:0] w [5];

    maxnet_host_ctrl #(.TIMEOUT_CYCLES(c_TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .mx_start     (mx_start),
        .mx_eps       (mx_eps),
        .mx_a1        (mx_a1),
        .mx_a2        (mx_a2),
        .mx_a3        (mx_a3),
        .mx_a4        (mx_a4),
        .mx_finish    (mx_finish),
        .mx_overflow  (mx_overflow),
        .mx_out       (mx_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_overflow (res_overflow),
        .res_timeout  (res_timeout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ops(input string tag);
        chk({tag, "_eps"}, mx_eps, m_ops[0]);
        chk({tag, "_a1"},  mx_a1,  m_ops[1]);
        chk({tag, "_a2"},  mx_a2,  m_ops[2]);
        chk({tag, "_a3"},  mx_a3,  m_ops[3]);
        chk({tag, "_a4"},  mx_a4,  m_ops[4]);
    endtask

    // mode 0: continuous valid, 1: valid toggles every other cycle, 2: random gaps.
    // Returns in the START cycle.
    task automatic do_load(input int mode);
        int n;
        for (int i = 0; i < 5; i++) begin
            if (mode == 1 && i > 0) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                tick();
            end else if (mode == 2) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid = 1'b0;
                    in_data  = $urandom;
                    tick();
                end
            end
            in_valid = 1'b1;
            in_data  = w[i];
            n = 0;
            while (in_ready !== 1'b1 && n < 8) begin
                tick();
                n++;
            end
            chk("load_in_ready", {31'b0, in_ready}, 32'd1);
            chk("load_no_start", {31'b0, mx_start}, 32'd0);
            tick();
            m_ops[i] = w[i];
        end
        in_valid = 1'b0;
        chk("start_pulse", {31'b0, mx_start}, 32'd1);
        chk("start_in_ready", {31'b0, in_ready}, 32'd0);
        chk("start_busy", {31'b0, busy}, 32'd1);
        chk_ops("start");
    endtask

    // d = WAIT cycle (1-based) in which the stub core shows finish; 0 = never.
    // Called in the START cycle; returns in the first RESP cycle.
    task automatic do_wait(input int d, input logic [31:0] o, input logic ov);
        int  lim;
        bit  tmo;
`ifdef MAXNET_TIMEOUT_EN
        tmo = (d == 0) || (d > c_TO);
`else
        tmo = 1'b0;
`endif
        lim = tmo ? c_TO : d;
        for (int c = 1; c <= lim; c++) begin
            tick();
            chk("wait_no_valid", {31'b0, res_valid}, 32'd0);
            chk("wait_no_start", {31'b0, mx_start}, 32'd0);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            if (c == d) begin
                mx_finish   = 1'b1;
                mx_out      = o;
                mx_overflow = ov;
            end else begin
                mx_finish   = 1'b0;
                mx_out      = $urandom;
                mx_overflow = 1'($urandom_range(0, 1));
            end
        end
        tick();
        in_valid = 1'b0;
        m_tmo  = tmo;
        m_data = tmo ? 32'h0 : o;
        m_ovf  = tmo ? 1'b0 : ov;
        chk("resp_valid", {31'b0, res_valid}, 32'd1);
        chk("resp_data", res_data, m_data);
        chk("resp_overflow", {31'b0, res_overflow}, {31'b0, m_ovf});
        chk("resp_timeout", {31'b0, res_timeout}, {31'b0, m_tmo});
        chk_ops("resp");
    endtask

    // Holds res_ready low for 'hold' cycles while the core toggles junk, then accepts.
    task automatic do_resp(input int hold);
        for (int k = 0; k < hold; k++) begin
            mx_finish   = 1'b1;
            mx_out      = $urandom;
            mx_overflow = 1'($urandom_range(0, 1));
            tick();
            chk("hold_valid", {31'b0, res_valid}, 32'd1);
            chk("hold_data", res_data, m_data);
            chk("hold_overflow", {31'b0, res_overflow}, {31'b0, m_ovf});
            chk("hold_timeout", {31'b0, res_timeout}, {31'b0, m_tmo});
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("ack_valid", {31'b0, res_valid}, 32'd0);
        chk("ack_in_ready", {31'b0, in_ready}, 32'd1);
        chk("ack_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) m_ops[i] = 32'h0;

        // Reset state while rst is asserted.
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_start", {31'b0, mx_start}, 32'd0);
        chk("rst_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_res_data", res_data, 32'h0);
        chk_ops("rst");
        #23 rst = 1'b0;
        tick();
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Load-and-start vector, finish 20 cycles after start.
        w[0] = 32'hBE4CCCCD; w[1] = 32'h461C3FA7; w[2] = 32'hC61C3FA7;
        w[3] = 32'h461C3FA7; w[4] = 32'hC61C3FA7;
        do_load(0);
        do_wait(20, 32'h461C3FA7, 1'b0);
        do_resp(0);

        // Toggling in_valid during load, backpressure for 5 cycles.
        for (int i = 0; i < 5; i++) w[i] = $urandom;
        do_load(1);
        do_wait(3, 32'h12345678, 1'b1);
        do_resp(5);

        // Stale finish held from the previous run through START with junk data.
        chk("stale_finish_level", {31'b0, mx_finish}, 32'd1);
        for (int i = 0; i < 5; i++) w[i] = $urandom;
        do_load(2);
        mx_finish = 1'b1;
        mx_out    = 32'hDEADBEEF;
        do_wait(1, 32'h3F800000, 1'b0);
        do_resp(1);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 5; i++) w[i] = $urandom;
            do_load($urandom_range(0, 2));
            do_wait($urandom_range(1, 12), $urandom, 1'($urandom_range(0, 1)));
            do_resp($urandom_range(0, 5));
        end

`ifdef MAXNET_TIMEOUT_EN
        for (int i = 0; i < 5; i++) w[i] = $urandom;
        do_load(0);
        do_wait(0, 32'h0, 1'b0);
        do_resp(2);

        for (int i = 0; i < 5; i++) w[i] = $urandom;
        do_load(0);
        do_wait(c_TO, 32'hC61C3FA7, 1'b1);
        do_resp(0);
`endif

        // Reset in the middle of WAIT, between clock edges.
        for (int i = 0; i < 5; i++) w[i] = $urandom;
        do_load(0);
        mx_finish = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) m_ops[i] = 32'h0;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_start", {31'b0, mx_start}, 32'd0);
        chk("midrst_valid", {31'b0, res_valid}, 32'd0);
        chk_ops("midrst");
        #1 rst = 1'b0;
        tick();
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_busy_after", {31'b0, busy}, 32'd0);

        // A fresh run after reset still works.
        for (int i = 0; i < 5; i++) w[i] = $urandom;
        do_load(2);
        do_wait(2, 32'hCAFEF00D, 1'b1);
        do_resp(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
